// File: rtl/tree_pkg.sv
// Shared types and sizes for the priority tree and its interrupt dispatch stage.
package tree_pkg;

    localparam int TreeWidth    = 8;
    localparam int TreeValWidth = 32;
    localparam int TreeIdxWidth = $clog2(TreeWidth);

    typedef logic [TreeValWidth-1:0] TreeVal;
    typedef logic [TreeIdxWidth-1:0] TreeIdx;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        ACTIVE
    } TreeState;

endpackage

// File: rtl/tree.sv
// Combinational argmax over TreeWidth values; largest wins, ties go to the higher index.
module tree
    import tree_pkg::*;
(
    input  TreeVal [TreeWidth-1:0] values_i,
    output TreeIdx                 win_idx_o,
    output TreeVal                 win_val_o
);

    localparam int NodeCount = 2 * TreeWidth - 1;

    // Heap layout: node n has children 2n+1 (lower index) and 2n+2 (higher index).
    TreeVal node_val [NodeCount];
    TreeIdx node_idx [NodeCount];

    always_comb begin
        for (int n = 0; n < NodeCount; n++) begin
            node_val[n] = '0;
            node_idx[n] = '0;
        end
        for (int i = 0; i < TreeWidth; i++) begin
            node_val[TreeWidth-1+i] = values_i[i];
            node_idx[TreeWidth-1+i] = TreeIdx'(i);
        end
        // >= so that equal values resolve toward the higher-index subtree.
        for (int n = TreeWidth - 2; n >= 0; n--) begin
            if (node_val[2*n+2] >= node_val[2*n+1]) begin
                node_val[n] = node_val[2*n+2];
                node_idx[n] = node_idx[2*n+2];
            end else begin
                node_val[n] = node_val[2*n+1];
                node_idx[n] = node_idx[2*n+1];
            end
        end
    end

    assign win_idx_o = node_idx[0];
    assign win_val_o = node_val[0];

endmodule

// File: rtl/tree_dispatch.sv
// Interrupt dispatch: latches pending events, picks the winner through the tree and
// offers one interrupt at a time to the core until it reports completion.
module tree_dispatch
    import tree_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TreeWidth-1:0] pend_set,
    input  logic [TreeWidth-1:0] enable,
    input  TreeVal [TreeWidth-1:0] prio,
    input  TreeVal               threshold,
    output logic                 req_valid,
    output TreeIdx               req_id,
    output TreeVal               req_prio,
    input  logic                 req_ready,
    input  logic                 done,
    output logic [TreeWidth-1:0] pending,
    output logic [TreeWidth-1:0] overrun
);

    TreeState             state_q, state_d;
    logic                 req_valid_q, req_valid_d;
    TreeIdx               req_id_q, req_id_d;
    TreeVal               req_prio_q, req_prio_d;
    logic [TreeWidth-1:0] pending_q, pending_d;
    logic [TreeWidth-1:0] overrun_q, overrun_d;

    TreeVal [TreeWidth-1:0] tree_vals;
    TreeIdx               win_idx;
    TreeVal               win_val;
    logic                 qualify;
    logic                 accept;
    logic [TreeWidth-1:0] clr_mask;

    for (genvar gi = 0; gi < TreeWidth; gi++) begin : g_mask
        assign tree_vals[gi] = (pending_q[gi] & enable[gi]) ? prio[gi] : '0;
    end

    tree u_tree (
        .values_i  (tree_vals),
        .win_idx_o (win_idx),
        .win_val_o (win_val)
    );

    assign qualify = (win_val > threshold);

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_id_d    = req_id_q;
        req_prio_d  = req_prio_q;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (qualify) begin
                    req_valid_d = 1'b1;
                    req_id_d    = win_idx;
                    req_prio_d  = win_val;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                // The offer is committed: nothing but the handshake (or reset) retires it.
                if (req_ready) begin
                    accept      = 1'b1;
                    req_valid_d = 1'b0;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        clr_mask = '0;
        if (accept) begin
            clr_mask[req_id_q] = 1'b1;
        end
    end

    // A new event on the source being accepted re-queues it rather than counting as overrun.
    assign pending_d = (pending_q & ~clr_mask) | pend_set;
    assign overrun_d = overrun_q | (pend_set & pending_q & ~clr_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_id_q    <= '0;
            req_prio_q  <= '0;
            pending_q   <= '0;
            overrun_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_id_q    <= req_id_d;
            req_prio_q  <= req_prio_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_id    = req_id_q;
    assign req_prio  = req_prio_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule
